// File: rtl/regfile_wb_arbiter_if.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundles the write-back requester handshake and the register file write port
// shared by the write-back arbiter.
//
// Parameters:
//   NREQ        number of write-back requesters (index 0 = pipeline)
// Signals:
//   req_valid   per-requester write request
//   req_rd      destination register, requester i at [5i+4:5i]
//   req_data    write data, requester i at [32i+31:32i]
//   req_ready   one-hot grant (handshake = valid && ready)
//   stall_pipe  forced-grant cycle, pipeline must hold its writeback
//   RegWriteW   register file write enable
//   wb_rd       register file destination address
//   ResultW     register file write data
// Modports:
//   master      requester / register-file side
//   slave       arbiter side
// ----------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]    req_valid;
    logic [5*NREQ-1:0]  req_rd;
    logic [32*NREQ-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               stall_pipe;
    logic               RegWriteW;
    logic [4:0]         wb_rd;
    logic [31:0]        ResultW;

    modport master (
        output req_valid, req_rd, req_data,
        input  req_ready, stall_pipe, RegWriteW, wb_rd, ResultW
    );

    modport slave (
        input  req_valid, req_rd, req_data,
        output req_ready, stall_pipe, RegWriteW, wb_rd, ResultW
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the register file's single write port among NREQ write-back
// requesters. Requester 0 (the in-order pipeline) has fixed highest priority;
// requesters 1..NREQ-1 are served round-robin. The winner's rd/data are
// registered and presented on the write port one cycle after the handshake.
// Writes to x0 complete the handshake but never raise RegWriteW.
//
// Optional feature macro: STARVE_GUARD_EN
//   defined   - a wait counter tracks how long low-priority requesters have
//               been blocked by requester 0; at MAX_WAIT the round-robin winner
//               is force-granted and stall_pipe is raised for that cycle.
//   undefined - no wait counter, stall_pipe tied low, requester 0 always wins.
//
// Parameters:
//   NREQ      number of requesters (2..8)
//   MAX_WAIT  blocked cycles before a forced grant (1..255)
// Ports:
//   clk       clock, all state changes on posedge
//   reset_n   asynchronous active-low reset
//   bus       regfile_wb_arbiter_if.slave (requests, grants, write port)
// ----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int NREQ     = 3,
    parameter int MAX_WAIT = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_param
        $error("regfile_wb_arbiter: NREQ must be 2..8 and MAX_WAIT 1..255");
    end

    // Registered state
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             reg_write_q, reg_write_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic [31:0]      result_q, result_d;

`ifdef STARVE_GUARD_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

    // Arbitration signals
    logic             lo_valid;
    logic             hi_found;
    logic [PTR_W-1:0] hi_first, lo_first, rr_idx;
    logic             forced;
    logic [NREQ-1:0]  grant;
    logic             lo_grant;
    logic [4:0]       sel_rd;
    logic [31:0]      sel_data;

    // Round-robin pick among 1..NREQ-1: the lowest valid index at or above
    // rr_ptr wins; if none, wrap to the lowest valid index overall.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        lo_valid = 1'b0;
        hi_found = 1'b0;
        hi_first = '0;
        lo_first = '0;
        for (int j = NREQ - 1; j >= 1; j--) begin
            if (bus.req_valid[j]) begin
                lo_valid = 1'b1;
                lo_first = PTR_W'(j);
                if (j >= int'(rr_ptr_q)) begin
                    hi_found = 1'b1;
                    hi_first = PTR_W'(j);
                end
            end
        end
        rr_idx = hi_found ? hi_first : lo_first;
    end

`ifdef STARVE_GUARD_EN
    assign forced = lo_valid && (wait_cnt_q == WAIT_W'(MAX_WAIT));
`else
    assign forced = 1'b0;
`endif

    // Grant selection; grants and stall are held low while reset is asserted.
    always_comb begin
        grant          = '0;
        bus.stall_pipe = 1'b0;
        if (reset_n) begin
            if (forced) begin
                grant[rr_idx]  = 1'b1;
                bus.stall_pipe = 1'b1;
            end else if (bus.req_valid[0]) begin
                grant[0] = 1'b1;
            end else if (lo_valid) begin
                grant[rr_idx] = 1'b1;
            end
        end
    end

    assign bus.req_ready = grant;
    assign lo_grant      = |grant[NREQ-1:1];

    // Next-state logic
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (grant[j]) begin
                sel_rd   = bus.req_rd[j*5 +: 5];
                sel_data = bus.req_data[j*32 +: 32];
            end
        end

        // An rd==0 handshake completes but must not write x0; address and
        // data then keep their previous value like any idle cycle.
        reg_write_d = (|grant) && (sel_rd != 5'd0);
        wb_rd_d     = reg_write_d ? sel_rd   : wb_rd_q;
        result_d    = reg_write_d ? sel_data : result_q;

        rr_ptr_d = rr_ptr_q;
        for (int j = 1; j < NREQ; j++) begin
            if (grant[j]) begin
                rr_ptr_d = (j == NREQ - 1) ? PTR_W'(1) : PTR_W'(j + 1);
            end
        end

`ifdef STARVE_GUARD_EN
        wait_cnt_d = wait_cnt_q;
        if (lo_grant) begin
            wait_cnt_d = '0;
        end else if (grant[0] && lo_valid && wait_cnt_q != WAIT_W'(MAX_WAIT)) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: every flop here is real control/data state and is reset, so an
        // in-flight write is dropped the moment reset_n falls.
        if (!reset_n) begin
            rr_ptr_q    <= PTR_W'(1);
            reg_write_q <= 1'b0;
            wb_rd_q     <= '0;
            result_q    <= '0;
`ifdef STARVE_GUARD_EN
            wait_cnt_q  <= '0;
`endif
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            reg_write_q <= reg_write_d;
            wb_rd_q     <= wb_rd_d;
            result_q    <= result_d;
`ifdef STARVE_GUARD_EN
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

    assign bus.RegWriteW = reg_write_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.ResultW   = result_q;

endmodule
